// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port, with a pending-write scoreboard and rs/rt hazard flag.
// Define REGFILE_WB_FIXED_PRIO_EN to make A always win ties (no last-grant flop); default is round-robin.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [INDEX_WIDTH-1:0]      issue_index,
    input  logic [INDEX_WIDTH-1:0]      rs_index,
    input  logic [INDEX_WIDTH-1:0]      rt_index,
    output logic                        hazard,
    input  logic                        a_valid,
    input  logic [INDEX_WIDTH-1:0]      a_index,
    input  logic [DATA_WIDTH-1:0]       a_data,
    output logic                        a_ready,
    input  logic                        b_valid,
    input  logic [INDEX_WIDTH-1:0]      b_index,
    input  logic [DATA_WIDTH-1:0]       b_data,
    output logic                        b_ready,
    output logic                        write_enable,
    output logic [INDEX_WIDTH-1:0]      rd_index,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [2**INDEX_WIDTH-1:0]   busy_mask
);

    localparam int NUM_REGS = 2**INDEX_WIDTH;

    logic                   grant_a;
    logic                   grant_b;
    logic [INDEX_WIDTH-1:0] wr_index;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   we_d, we_q;
    logic [INDEX_WIDTH-1:0] index_d, index_q;
    logic [DATA_WIDTH-1:0]  data_d, data_q;
    logic [NUM_REGS-1:0]    busy_set, busy_clr;
    logic [NUM_REGS-1:0]    busy_d, busy_q;

`ifdef REGFILE_WB_FIXED_PRIO_EN
    always_comb begin
        grant_a = a_valid && !reset;
        grant_b = b_valid && !a_valid && !reset;
    end
`else
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e last_grant_d, last_grant_q;

    // Gating with reset makes both readies fall the instant reset rises, not at the next edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        last_grant_d = last_grant_q;
        if (!reset) begin
            if (a_valid && b_valid) begin
                grant_a = (last_grant_q == GRANT_B);
                grant_b = (last_grant_q == GRANT_A);
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
        if (grant_a) begin
            last_grant_d = GRANT_A;
        end else if (grant_b) begin
            last_grant_d = GRANT_B;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GRANT_B;
        end else begin
            // NOTE: flops always use non-blocking assignment so every register samples pre-edge values.
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        wr_index = a_index;
        wr_data  = a_data;
        if (grant_b) begin
            wr_index = b_index;
            wr_data  = b_data;
        end
        // r0 is hardwired: the transfer is accepted but never reaches the register file.
        we_d    = (grant_a || grant_b) && (wr_index != '0);
        index_d = we_d ? wr_index : index_q;
        data_d  = we_d ? wr_data  : data_q;
    end

    // Clear on the commit edge, set on the reservation edge; set is applied last so a new reservation survives.
    always_comb begin
        busy_clr = '0;
        busy_set = '0;
        if (we_q) begin
            busy_clr[index_q] = 1'b1;
        end
        if (issue_valid && (issue_index != '0)) begin
            busy_set[issue_index] = 1'b1;
        end
        busy_d = (busy_q & ~busy_clr) | busy_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            index_q <= index_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign hazard       = ((rs_index != '0) && busy_q[rs_index]) ||
                          ((rt_index != '0) && busy_q[rt_index]);
    assign write_enable = we_q;
    assign rd_index     = index_q;
    assign rd_data      = data_q;
    assign busy_mask    = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (scoreboard array, last winner, pending write).
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int IW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [IW-1:0] issue_index, rs_index, rt_index;
    logic          hazard;
    logic          a_valid, b_valid;
    logic [IW-1:0] a_index, b_index;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          write_enable;
    logic [IW-1:0] rd_index;
    logic [DW-1:0] rd_data;
    logic [NR-1:0] busy_mask;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_index(issue_index),
        .rs_index(rs_index), .rt_index(rt_index), .hazard(hazard),
        .a_valid(a_valid), .a_index(a_index), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_index(b_index), .b_data(b_data), .b_ready(b_ready),
        .write_enable(write_enable), .rd_index(rd_index), .rd_data(rd_data),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: which registers await a write, who won last, and the write now on the port.
    bit            m_busy[NR];
    bit            m_last_a;
    bit            m_we;
    logic [IW-1:0] m_idx;
    logic [DW-1:0] m_data;
    bit            e_a, e_b, e_haz;
    bit            a_taken, b_taken;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_mask();
        logic [NR-1:0] m;
        for (int i = 0; i < NR; i++) m[i] = m_busy[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_last_a = 1'b0;
        m_we     = 1'b0;
        m_idx    = '0;
        m_data   = '0;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_index = '0; rs_index = '0; rt_index = '0;
        a_valid = 1'b0; a_index = '0; a_data = '0;
        b_valid = 1'b0; b_index = '0; b_data = '0;
    endtask

    task automatic predict();
        e_haz = (rs_index != 0 && m_busy[rs_index]) || (rt_index != 0 && m_busy[rt_index]);
`ifdef REGFILE_WB_FIXED_PRIO_EN
        e_a = a_valid;
        e_b = b_valid && !a_valid;
`else
        if (a_valid && b_valid) begin
            e_a = !m_last_a;
            e_b = m_last_a;
        end else begin
            e_a = a_valid;
            e_b = b_valid;
        end
`endif
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        #1;
        predict();
        check("a_ready", a_ready, e_a);
        check("b_ready", b_ready, e_b);
        check("hazard", hazard, e_haz);
        check("write_enable", write_enable, m_we);
        if (m_we) begin
            check("rd_index", rd_index, m_idx);
            check("rd_data", rd_data, m_data);
        end
        check("busy_mask", busy_mask, model_mask());
        @(posedge clk);
        if (m_we) m_busy[m_idx] = 1'b0;
        if (issue_valid && issue_index != 0) m_busy[issue_index] = 1'b1;
        a_taken = e_a;
        b_taken = e_b;
        m_we    = 1'b0;
        if (e_a || e_b) begin
            m_last_a = e_a;
            if (e_a && a_index != 0) begin
                m_we = 1'b1; m_idx = a_index; m_data = a_data;
            end else if (e_b && b_index != 0) begin
                m_we = 1'b1; m_idx = b_index; m_data = b_data;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_a;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_we", write_enable, 0);
        check("reset_rd_index", rd_index, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_busy", busy_mask, 0);
        reset = 1'b0;

        // Mid-stream reset with r2, r8 reserved and a write on the port.
        issue_valid = 1'b1; issue_index = 5'd2;
        cycle();
        issue_index = 5'd8;
        a_valid = 1'b1; a_index = 5'd12; a_data = 32'hCAFE_0012;
        cycle();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_index = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_index = 5'd4; b_data = 32'h22;
        rs_index = 5'd2;
        #1;
        check("pre_reset_busy", busy_mask, 32'h0000_0104);
        check("pre_reset_we", write_enable, 1);
        check("pre_reset_hazard", hazard, 1);
        reset = 1'b1;
        #1;
        check("async_reset_busy", busy_mask, 0);
        check("async_reset_we", write_enable, 0);
        check("async_reset_a_ready", a_ready, 0);
        check("async_reset_b_ready", b_ready, 0);
        check("async_reset_hazard", hazard, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        rs_index = '0;

        // Contention: A wins the first tie after reset, then alternation (fixed priority: A always).
        for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_WB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = (k % 2 == 0);
`endif
            #1;
            check("rr_a_grant", a_ready, exp_a);
            check("rr_b_grant", b_ready, !exp_a);
            cycle();
            check("rr_we_stream", write_enable, 1);
            if (a_taken) a_data = a_data + 32'h100;
            if (b_taken) b_data = b_data + 32'h100;
        end
        idle_inputs();
        cycle();

        // Single requester latency.
        a_valid = 1'b1; a_index = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        check("single_a_ready", a_ready, 1);
        cycle();
        a_valid = 1'b0;
        check("single_we", write_enable, 1);
        check("single_rd_index", rd_index, 5);
        check("single_rd_data", rd_data, 32'hDEAD_BEEF);
        cycle();
        check("single_we_off", write_enable, 0);

        // Scoreboard and hazard through a commit of r7.
        issue_valid = 1'b1; issue_index = 5'd7;
        cycle();
        issue_valid = 1'b0; rs_index = 5'd7; rt_index = '0;
        #1;
        check("haz_reserved", hazard, 1);
        cycle();
        a_valid = 1'b1; a_index = 5'd7; a_data = 32'h77;
        cycle();
        a_valid = 1'b0;
        check("haz_commit_cycle", hazard, 1);
        check("haz_commit_we", write_enable, 1);
        cycle();
        check("haz_after_commit", hazard, 0);
        rs_index = '0;
        issue_valid = 1'b1; issue_index = '0;
        cycle();
        issue_valid = 1'b0;
        check("r0_never_reserved", busy_mask[0], 0);

        // Same-edge set and clear of r9.
        issue_valid = 1'b1; issue_index = 5'd9;
        cycle();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_index = 5'd9; a_data = 32'h99;
        cycle();
        a_valid = 1'b0;
        check("same_edge_we", write_enable, 1);
        check("same_edge_rd_index", rd_index, 9);
        issue_valid = 1'b1; issue_index = 5'd9;
        cycle();
        issue_valid = 1'b0;
        check("same_edge_busy9", busy_mask[9], 1);

        // Transfer to r0 is accepted and dropped.
        b_valid = 1'b1; b_index = '0; b_data = 32'h1234;
        #1;
        check("r0_b_ready", b_ready, 1);
        cycle();
        b_valid = 1'b0;
        check("r0_we", write_enable, 0);
        check("r0_busy", busy_mask[0], 0);
        cycle();

        // Randomized traffic: requesters hold until accepted; issue never asserted under hazard.
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            if (!a_valid || a_taken) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_index = IW'($urandom);
                a_data  = $urandom;
            end
            if (!b_valid || b_taken) begin
                b_valid = ($urandom_range(0, 2) == 0);
                b_index = IW'($urandom);
                b_data  = $urandom;
            end
            rs_index = IW'($urandom);
            rt_index = IW'($urandom);
            predict();
            issue_index = IW'($urandom);
            issue_valid = !e_haz && ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates between two writeback requesters:
  - A: main ALU/load pipeline.
  - B: multi-cycle mult/div unit.
- Drives the registered write_enable/rd_index/rd_data to the register file.
- Keeps a pending-write scoreboard and flags read hazards on rs/rt to the issue stage.

Parameters:
- DATA_WIDTH, 32, writeback data width.
- INDEX_WIDTH, 5, register index width; scoreboard depth is 2**INDEX_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- issue_valid  input  1  instruction issuing this cycle reserves a destination.
- issue_index  input  INDEX_WIDTH  destination being reserved.
- rs_index  input  INDEX_WIDTH  source 1 of the issuing instruction.
- rt_index  input  INDEX_WIDTH  source 2 of the issuing instruction.
- hazard  output  1  rs or rt has a pending write; issue must stall.
- a_valid  input  1  requester A has a result.
- a_index  input  INDEX_WIDTH  A destination.
- a_data  input  DATA_WIDTH  A result.
- a_ready  output  1  A granted this cycle.
- b_valid  input  1  requester B has a result.
- b_index  input  INDEX_WIDTH  B destination.
- b_data  input  DATA_WIDTH  B result.
- b_ready  output  1  B granted this cycle.
- write_enable  output  1  register file write strobe (registered).
- rd_index  output  INDEX_WIDTH  register file write index (registered).
- rd_data  output  DATA_WIDTH  register file write data (registered).
- busy_mask  output  2**INDEX_WIDTH  scoreboard, bit i = register i pending.

Behaviour:
- Reset (async, any time):
  - write_enable=0, rd_index=0, rd_data=0, busy_mask=0.
  - last_grant=B, so A wins the first tie.
  - An in-flight write is dropped; ready and hazard fall combinationally once reset is high.
- Handshake:
  - A transfer occurs on the edge where valid&&ready.
  - ready is combinational from valid and arbiter state; it never depends on the same requester's ready.
  - A requester holds valid/index/data stable until accepted.
- Arbitration (round-robin):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the one not granted last.
  - last_grant updates only on an actual grant.
  - At most one ready high per cycle.
- Latency:
  - Grant in cycle N -> write_enable=1 with captured index/data in cycle N+1.
  - The register file commits at the end of N+1.
  - No grant in N -> write_enable=0 in N+1, rd_index/rd_data hold previous values.
  - Throughput is one write per cycle.
- Index 0:
  - A granted transfer to r0 is accepted (ready=1) but produces write_enable=0 in N+1.
  - r0 is never written and its scoreboard bit never sets.
- Scoreboard:
  - busy[i] sets on the edge with issue_valid && issue_index==i && i!=0.
  - busy[i] clears on the edge with write_enable && rd_index==i, i.e. the commit edge.
  - Set and clear of the same index on the same edge -> set wins, because the newer reservation survives.
  - Setting an already-busy bit is legal; no counting (one outstanding write per register is enforced upstream by hazard).
- Hazard:
  - hazard = (rs_index!=0 && busy[rs_index]) || (rt_index!=0 && busy[rt_index]), combinational.
  - A register being committed this cycle still reads busy; hazard drops the cycle after commit, when the register file holds the new value.
- issue_valid is not gated by hazard inside this block; the issue stage must not assert issue_valid while hazard=1.

Optional Feature:
- REGFILE_WB_FIXED_PRIO_EN defined:
  - A always wins when both are valid; last_grant flop is removed.
  - B is granted only when a_valid=0.
- Undefined: round-robin as above.

Test Plan:
- Reset values: assert reset mid-stream with busy_mask=0x0000_0104 and a pending grant -> immediately busy_mask=0, write_enable=0, a_ready=b_ready=0; after release, A wins first tie.
- Single requester: a_valid=1, a_index=5, a_data=0xDEADBEEF in cycle N -> a_ready=1 in N; write_enable=1, rd_index=5, rd_data=0xDEADBEEF in N+1; write_enable=0 in N+2.
- Round-robin contention: A (idx 3, 0x11) and B (idx 4, 0x22) valid for 4 cycles, each re-presenting new data after acceptance -> grants alternate A,B,A,B; write_enable high 4 consecutive cycles. With REGFILE_WB_FIXED_PRIO_EN -> A,A,A,A and b_ready=0 throughout.
- Scoreboard/hazard: issue_index=7, then rs_index=7 -> hazard=1 until the cycle after the commit of r7; rt_index=0 never raises hazard.
- Same-edge set/clear: commit r9 on the same edge as issue_valid, issue_index=9 -> busy[9] remains 1.
- r0 drop: b_valid=1, b_index=0, b_data=0x1234 -> b_ready=1, write_enable stays 0 in N+1, busy[0]=0.
